// File: rtl/ram_access_ctrl_pkg.sv
// Shared encodings for ram_access_ctrl: access sizes, FSM states and the alignment rule.
// The alignment rule is only consulted when RAM_ACCESS_CTRL_MISALIGN_ERR_EN is defined.
package ram_access_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Size encoding 3 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ram_lane_merge.sv
// Byte-lane logic: merges store data into a RAM word and extracts/extends load data.
module ram_lane_merge
    import ram_access_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = word_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        merged_o = word_i;
        load_o   = word_i;
        case (size_i)
            SIZE_BYTE: begin
                merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
            end
            SIZE_HALF: begin
                merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                load_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
            end
            default: begin
                merged_o = wdata_i;
                load_o   = word_i;
            end
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sub-word load/store controller in front of a word-only RAM (read-modify-write for stores).
// Define RAM_ACCESS_CTRL_MISALIGN_ERR_EN to reject misaligned half/word accesses with resp_err_o.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              err_q, err_d;

    logic              misalign;
    logic              accept;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_data;

    ram_lane_merge u_lane_merge (
        .word_i     (word_q),
        .wdata_i    (wdata_q),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .merged_o   (merged),
        .load_o     (load_data)
    );

`ifdef RAM_ACCESS_CTRL_MISALIGN_ERR_EN
    assign misalign = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign accept = req_valid_i && req_ready_o;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    err_d   = misalign;
                    state_d = misalign ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                word_d  = ram_rdata_i;
                state_d = we_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by rst directly so they read as reset values during the reset cycle itself.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_err_o   = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = '0;
        ram_wdata_o  = '0;
        if (!rst) begin
            ram_addr_o = addr_q;
            case (state_q)
                ST_IDLE: req_ready_o = 1'b1;
                ST_READ: ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
                ST_WRITE: begin
                    ram_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                    ram_we_o    = 1'b1;
                    ram_wdata_o = merged;
                end
                ST_RESP: begin
                    resp_valid_o = 1'b1;
                    resp_err_o   = err_q;
                    resp_rdata_o = (we_q || err_q) ? '0 : load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed vector table, reset corner cases and
// randomized transactions against an arithmetic load/store model of a 16-word RAM.
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;
    int          we_cnt = 0;
    int          n_checks = 0;
    int          n_fails = 0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    assign ram_rdata_i = mem[ram_addr_o[5:2]];

    always @(posedge clk) begin
        if (ram_we_o) begin
            mem[ram_addr_o[5:2]] <= ram_wdata_o;
            we_cnt <= we_cnt + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain shift/mask arithmetic on whole words.
    function automatic logic m_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef RAM_ACCESS_CTRL_MISALIGN_ERR_EN
        return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned m_shift(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return (a % 4) * 8;
        if (sz == 2'd1) return ((a / 2) % 2) * 16;
        return 0;
    endfunction

    function automatic logic [31:0] m_mask(input logic [1:0] sz);
        if (sz == 2'd0) return 32'h0000_00FF;
        if (sz == 2'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
        logic [31:0] v;
        logic [31:0] m;
        m = m_mask(sz);
        v = (w >> m_shift(a, sz)) & m;
        if (!u && sz == 2'd0 && v[7])  v = v | ~m;
        if (!u && sz == 2'd1 && v[15]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] m;
        m = m_mask(sz) << m_shift(a, sz);
        return (w & ~m) | ((d << m_shift(a, sz)) & m);
    endfunction

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        pl_en = 1'b1;
        pl_idx = idx;
        pl_data = data;
        ref_mem[idx] = data;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [1:0] sz, input logic u, input logic [31:0] wdata,
                           input int hold, input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input logic [31:0] exp_word);
        int lat;
        int we_at;
        int base;
        logic [31:0] rd0;
        chk({name, ".ready_idle"}, {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_we_i = we;
        req_addr_i = addr;
        req_size_i = sz;
        req_unsigned_i = u;
        req_wdata_i = wdata;
        base = we_cnt;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_wdata_i = $urandom;
        lat = 1;
        we_at = -1;
        while (!resp_valid_o && lat < 8) begin
            if (ram_we_o) begin
                we_at = lat;
                chk({name, ".ram_addr"}, ram_addr_o, {addr[31:2], 2'b00});
                chk({name, ".ram_wdata"}, ram_wdata_o, exp_word);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".we_cycle"}, we_at, (we && !exp_err) ? 2 : -1);
        chk({name, ".we_pulses"}, we_cnt - base, (we && !exp_err) ? 1 : 0);
        chk({name, ".rdata"}, resp_rdata_o, exp_rdata);
        chk({name, ".err"}, {31'd0, resp_err_o}, {31'd0, exp_err});
        rd0 = resp_rdata_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, ".hold_valid"}, {31'd0, resp_valid_o}, 32'd1);
            chk({name, ".hold_rdata"}, resp_rdata_o, rd0);
            chk({name, ".hold_err"}, {31'd0, resp_err_o}, {31'd0, exp_err});
            chk({name, ".hold_ready"}, {31'd0, req_ready_o}, 32'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        chk({name, ".valid_drop"}, {31'd0, resp_valid_o}, 32'd0);
        chk({name, ".word"}, mem[addr[5:2]], exp_word);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".ready"}, {31'd0, req_ready_o}, 32'd0);
        chk({name, ".valid"}, {31'd0, resp_valid_o}, 32'd0);
        chk({name, ".rdata"}, resp_rdata_o, 32'd0);
        chk({name, ".err"}, {31'd0, resp_err_o}, 32'd0);
        chk({name, ".we"}, {31'd0, ram_we_o}, 32'd0);
        chk({name, ".addr"}, ram_addr_o, 32'd0);
        chk({name, ".wdata"}, ram_wdata_o, 32'd0);
    endtask

    // Store interrupted by reset rst_at cycles after acceptance (1 = READ, 2 = WRITE).
    task automatic rst_txn(input string name, input int rst_at);
        int base;
        preload(4'd6, 32'h5566_7788);
        req_valid_i = 1'b1;
        req_we_i = 1'b1;
        req_addr_i = 32'h18;
        req_size_i = 2'd0;
        req_unsigned_i = 1'b0;
        req_wdata_i = 32'h99;
        base = we_cnt;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int i = 1; i < rst_at; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk_reset_outputs({name, ".in_cycle"});
        @(posedge clk); #1;
        chk_reset_outputs({name, ".next_cycle"});
        rst = 1'b0;
        #1;
        chk({name, ".ready_after"}, {31'd0, req_ready_o}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({name, ".no_write"}, we_cnt - base, 0);
        chk({name, ".word"}, mem[6], 32'h5566_7788);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] wdata;
        logic [31:0] init;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 32'h12, 2'd0, 1'b0, 32'h0000_00AB, 32'h1122_3344, 0, 32'h0, 1'b0, 3, 32'h11AB_3344};
        vecs[1] = '{1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 32'h80FF_0000, 5, 32'hFFFF_FF80, 1'b0, 2, 32'h80FF_0000};
        vecs[2] = '{1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 32'h80FF_0000, 0, 32'h0000_0080, 1'b0, 2, 32'h80FF_0000};
        vecs[3] = '{1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 1, 32'h0, 1'b0, 3, 32'hBEEF_0000};
        vecs[4] = '{1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 32'h8001_7FFF, 0, 32'hFFFF_8001, 1'b0, 2, 32'h8001_7FFF};
        vecs[5] = '{1'b0, 32'h20, 2'd1, 1'b0, 32'h0, 32'h8001_7FFF, 0, 32'h0000_7FFF, 1'b0, 2, 32'h8001_7FFF};
        vecs[6] = '{1'b0, 32'h24, 2'd3, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF};
`ifdef RAM_ACCESS_CTRL_MISALIGN_ERR_EN
        vecs[7] = '{1'b1, 32'h05, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h1234_5678, 2, 32'h0, 1'b1, 1, 32'h1234_5678};
        vecs[8] = '{1'b0, 32'h0A, 2'd2, 1'b0, 32'h0, 32'h0BAD_C0DE, 0, 32'h0, 1'b1, 1, 32'h0BAD_C0DE};
`else
        vecs[7] = '{1'b1, 32'h05, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h1234_5678, 2, 32'h0, 1'b0, 3, 32'hCAFE_F00D};
        vecs[8] = '{1'b0, 32'h0A, 2'd2, 1'b0, 32'h0, 32'h0BAD_C0DE, 0, 32'h0BAD_C0DE, 1'b0, 2, 32'h0BAD_C0DE};
`endif
        vecs[9] = '{1'b1, 32'h0C, 2'd0, 1'b0, 32'hFFFF_FF5A, 32'h0, 0, 32'h0, 1'b0, 3, 32'h0000_005A};

        rst = 1'b1;
        req_valid_i = 1'b1;
        req_we_i = 1'b0;
        req_addr_i = 32'h0;
        req_size_i = 2'd0;
        req_unsigned_i = 1'b0;
        req_wdata_i = 32'h0;
        resp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        req_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset.ready_after", {31'd0, req_ready_o}, 32'd1);

        for (int i = 0; i < 16; i++) preload(i[3:0], $urandom);

        for (int i = 0; i < 10; i++) begin
            preload(vecs[i].addr[5:2], vecs[i].init);
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].sz, vecs[i].u,
                    vecs[i].wdata, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err,
                    vecs[i].exp_lat, vecs[i].exp_word);
            ref_mem[vecs[i].addr[5:2]] = vecs[i].exp_word;
        end

        rst_txn("rst_read", 1);
        rst_txn("rst_write", 2);

        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic        u;
            logic        mis;
            logic [31:0] a;
            logic [31:0] d;
            logic [1:0]  sz;
            logic [3:0]  idx;
            logic [31:0] exp_word;
            logic [31:0] exp_rdata;
            we  = $urandom_range(0, 1) == 1;
            u   = $urandom_range(0, 1) == 1;
            a   = $urandom_range(0, 63);
            sz  = 2'($urandom_range(0, 3));
            d   = $urandom;
            idx = a[5:2];
            mis = m_mis(a, sz);
            exp_rdata = (we || mis) ? 32'h0 : m_load(ref_mem[idx], a, sz, u);
            exp_word  = (we && !mis) ? m_store(ref_mem[idx], a, sz, d) : ref_mem[idx];
            run_txn($sformatf("rnd%0d", i), we, a, sz, u, d, $urandom_range(0, 2),
                    exp_rdata, mis, mis ? 1 : (we ? 3 : 2), exp_word);
            ref_mem[idx] = exp_word;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
